// File: rtl/vdec_hs_fwd_if.sv
// Handshake/bus bundle between the Viterbi forward ACS stage and its
// sequencer, symbol RAM and ptram.
interface vdec_hs_fwd_if #(
  parameter int SW = 6
);
  logic            start;
  logic            busy;
  logic            done;
  logic [5:0]      codeblk_size_p7;
  logic            sym_rd;
  logic [5:0]      sym_addr;
  logic [3*SW-1:0] sym_dout;
  logic            pt_wr;
  logic [8:0]      pt_addr;
  logic [31:0]     pt_din;

  modport master (
    output start, codeblk_size_p7, sym_dout,
    input  busy, done, sym_rd, sym_addr, pt_wr, pt_addr, pt_din
  );

  modport slave (
    input  start, codeblk_size_p7, sym_dout,
    output busy, done, sym_rd, sym_addr, pt_wr, pt_addr, pt_din
  );
endinterface

// File: rtl/vdec_hs_fwd.sv
// Forward ACS stage of the rate-1/3 K=9 Viterbi decoder: 256 path metrics per
// trellis step, 32 states per cycle, one survivor-decision word per cycle.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | read strobe for step 0 symbols
// LOAD  | latch step 0 symbols
// ACS   | one 32-state group per cycle, 8 cycles per step
// FIN   | done pulse, then back to IDLE
module vdec_hs_fwd #(
  parameter int SW = 6,
  parameter int MW = 16
) (
  input logic          clk,
  input logic          rst,
  vdec_hs_fwd_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRIME, LOAD, ACS, FIN} state_t;

  localparam logic [26:0]          GEN     = {9'o711, 9'o663, 9'o557};
  localparam logic signed [MW-1:0] PM_INIT = {2'b11, {(MW-2){1'b0}}};

  state_t                 state_q;
  logic [5:0]             step_q;
  logic [2:0]             grp_q;
  logic [5:0]             len_q;
  logic                   bank_q;
  logic [3*SW-1:0]        sym_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   sym_rd_q;
  logic [5:0]             sym_addr_q;
  logic                   pt_wr_q;
  logic signed [MW-1:0]   pm_q [2][256];

  logic [31:0]            dec_d;
  logic signed [MW-1:0]   nm_d [32];

  // Taps are {p[7], s[7:0]}: x0 = s[0] is the input bit, x8 the oldest bit.
  function automatic logic signed [MW-1:0] branch_metric(
    input logic [7:0]      s,
    input logic            pb,
    input logic [3*SW-1:0] y
  );
    logic [8:0]           x;
    logic [8:0]           g;
    logic                 c;
    logic signed [MW-1:0] ye;
    logic signed [MW-1:0] acc;
    x   = {pb, s};
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      g = GEN[9*i +: 9];
      c = 1'b0;
      for (int j = 0; j < 9; j++) c = c ^ (g[8-j] & x[j]);
      ye  = {{(MW-SW){y[SW*i+SW-1]}}, y[SW*i +: SW]};
      acc = c ? acc - ye : acc + ye;
    end
    return acc;
  endfunction

  always_comb begin
    dec_d = '0;
    for (int b = 0; b < 32; b++) begin
      logic [7:0]           st;
      logic [7:0]           p0;
      logic [7:0]           p1;
      logic signed [MW-1:0] pm0;
      logic signed [MW-1:0] pm1;
      logic signed [MW-1:0] m0;
      logic signed [MW-1:0] m1;
      st = {grp_q, 5'(b)};
      p0 = {1'b0, st[7:1]};
      p1 = {1'b1, st[7:1]};
      // Step 0 starts from the known-state-0 metrics instead of the bank.
      if (step_q == 6'd0) begin
        pm0 = (p0 == 8'd0) ? '0 : PM_INIT;
        pm1 = PM_INIT;
      end else begin
        pm0 = pm_q[bank_q][p0];
        pm1 = pm_q[bank_q][p1];
      end
      m0       = pm0 + branch_metric(st, 1'b0, sym_q);
      m1       = pm1 + branch_metric(st, 1'b1, sym_q);
      dec_d[b] = (m1 > m0);
      nm_d[b]  = (m1 > m0) ? m1 : m0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      grp_q      <= '0;
      len_q      <= '0;
      bank_q     <= 1'b0;
      sym_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sym_rd_q   <= 1'b0;
      sym_addr_q <= '0;
      pt_wr_q    <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        pm_q[0][i] <= '0;
        pm_q[1][i] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      sym_rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= PRIME;
            busy_q     <= 1'b1;
            sym_rd_q   <= 1'b1;
            sym_addr_q <= '0;
            len_q      <= bus.codeblk_size_p7;
            step_q     <= '0;
            grp_q      <= '0;
            bank_q     <= 1'b0;
          end
        end
        PRIME: state_q <= LOAD;
        LOAD: begin
          sym_q   <= bus.sym_dout;
          pt_wr_q <= 1'b1;
          state_q <= ACS;
        end
        ACS: begin
          for (int b = 0; b < 32; b++) pm_q[~bank_q][{grp_q, 5'(b)}] <= nm_d[b];
          grp_q <= grp_q + 3'd1;
          // Fetch next step's symbols so they land exactly in group 7.
          if (grp_q == 3'd5 && step_q != len_q) begin
            sym_rd_q   <= 1'b1;
            sym_addr_q <= step_q + 6'd1;
          end
          if (grp_q == 3'd7) begin
            bank_q <= ~bank_q;
            if (step_q == len_q) begin
              pt_wr_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              step_q <= step_q + 6'd1;
              sym_q  <= bus.sym_dout;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sym_rd   = sym_rd_q;
  assign bus.sym_addr = sym_addr_q;
  assign bus.pt_wr    = pt_wr_q;
  assign bus.pt_addr  = pt_wr_q ? {step_q, grp_q} : 9'd0;
  assign bus.pt_din   = pt_wr_q ? dec_d : 32'd0;

endmodule

// File: tb/tb_vdec_hs_fwd.sv
// Scoreboard bench for vdec_hs_fwd: expected ptram/symbol/done traffic is
// queued per run and a negedge monitor pops and compares DUT activity.
module tb_vdec_hs_fwd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vdec_hs_fwd_if #(.SW(6)) bus();

  vdec_hs_fwd #(.SW(6), .MW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {logic [8:0] addr; logic [31:0] din; int cyc;} pt_exp_t;
  typedef struct {logic [5:0] addr; int cyc;} sym_exp_t;
  typedef struct {logic val; int cyc;} bit_exp_t;

  localparam logic [8:0] GEN_T [3] = '{9'o557, 9'o663, 9'o711};

  pt_exp_t  exp_pt[$];
  sym_exp_t exp_sym[$];
  int       exp_done[$];
  bit_exp_t exp_busy[$];

  logic [17:0] sym_mem [64];
  logic [31:0] cap [512];
  logic [28:0] info_bits;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;
  bit chk_zero = 1'b0;
  bit chk_bit0 = 1'b0;

  int       mon_rel;
  pt_exp_t  mon_pt;
  sym_exp_t mon_sym;
  bit_exp_t mon_busy;
  int       mon_done;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(string name, logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Symbol RAM: one-cycle read latency.
  always @(posedge clk) if (bus.sym_rd) bus.sym_dout <= sym_mem[bus.sym_addr];
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mon_rel = cyc - start_cyc;
    if (mon_en && !rst) begin
      if (bus.pt_wr) begin
        cap[bus.pt_addr] = bus.pt_din;
        if (exp_pt.size() == 0) fail_now("pt_unexpected", 32'(bus.pt_addr));
        else begin
          mon_pt = exp_pt.pop_front();
          check("pt_addr", 32'(bus.pt_addr), 32'(mon_pt.addr));
          check("pt_din", bus.pt_din, mon_pt.din);
          check("pt_cycle", mon_rel, mon_pt.cyc);
        end
        if (chk_zero) check("pt_din_tie_zero", bus.pt_din, 32'd0);
        if (chk_bit0 && bus.pt_addr[2:0] == 3'd0) check("pt_state0_bit", 32'(bus.pt_din[0]), 32'd0);
      end
      if (bus.sym_rd) begin
        if (exp_sym.size() == 0) fail_now("sym_unexpected", 32'(bus.sym_addr));
        else begin
          mon_sym = exp_sym.pop_front();
          check("sym_addr", 32'(bus.sym_addr), 32'(mon_sym.addr));
          check("sym_cycle", mon_rel, mon_sym.cyc);
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected", mon_rel);
        else begin
          mon_done = exp_done.pop_front();
          check("done_cycle", mon_rel, mon_done);
        end
      end
      if (exp_busy.size() != 0 && exp_busy[0].cyc == mon_rel) begin
        mon_busy = exp_busy.pop_front();
        check("busy", 32'(bus.busy), 32'(mon_busy.val));
      end
    end
  end

  function automatic logic code_bit(int i, logic [8:0] v);
    logic c;
    c = 1'b0;
    for (int j = 0; j < 9; j++) c = c ^ (GEN_T[i][8-j] & v[j]);
    return c;
  endfunction

  function automatic int sym_val(logic [17:0] w, int i);
    logic signed [5:0] t;
    t = w[6*i +: 6];
    return int'(t);
  endfunction

  // Full 256-state reference trellis in plain integers.
  task automatic model_run(int L, int cyc_limit);
    int          pm [256];
    int          nm [256];
    logic [31:0] word [8];
    logic [17:0] w;
    logic [8:0]  v;
    int          m0, m1, bm, p;
    pt_exp_t     e;
    for (int s = 0; s < 256; s++) pm[s] = (s == 0) ? 0 : -16384;
    m0 = 0;
    m1 = 0;
    for (int k = 0; k <= L; k++) begin
      w = sym_mem[k % 64];
      for (int g = 0; g < 8; g++) word[g] = '0;
      for (int s = 0; s < 256; s++) begin
        for (int pb = 0; pb < 2; pb++) begin
          p  = pb * 128 + s / 2;
          v  = 9'((p << 1) | (s % 2));
          bm = 0;
          for (int i = 0; i < 3; i++) bm += code_bit(i, v) ? -sym_val(w, i) : sym_val(w, i);
          if (pb == 0) m0 = pm[p] + bm;
          else         m1 = pm[p] + bm;
        end
        if (m1 > m0) begin
          nm[s] = m1;
          word[s / 32][s % 32] = 1'b1;
        end else nm[s] = m0;
      end
      pm = nm;
      for (int g = 0; g < 8; g++) begin
        if (3 + 8 * k + g < cyc_limit) begin
          e.addr = 9'(((k % 64) * 8) + g);
          e.din  = word[g];
          e.cyc  = 3 + 8 * k + g;
          exp_pt.push_back(e);
        end
      end
    end
  endtask

  task automatic encode(bit noise);
    logic [7:0] st;
    logic [8:0] v;
    logic       u;
    int         y;
    st = '0;
    for (int k = 0; k < 37; k++) begin
      u = (k < 29) ? info_bits[k] : 1'b0;
      v = {st, u};
      for (int i = 0; i < 3; i++) begin
        y = code_bit(i, v) ? -31 : 31;
        if (noise) y = y + int'($urandom_range(16, 0)) - 8;
        if (y > 31) y = 31;
        if (y < -32) y = -32;
        sym_mem[k][6*i +: 6] = 6'(y);
      end
      st = v[7:0];
    end
  endtask

  task automatic fill_sym(logic [5:0] y);
    for (int k = 0; k < 64; k++) sym_mem[k] = {y, y, y};
  endtask

  task automatic check_idle(string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_sym_rd"}, 32'(bus.sym_rd), 32'd0);
    check({tag, "_sym_addr"}, 32'(bus.sym_addr), 32'd0);
    check({tag, "_pt_wr"}, 32'(bus.pt_wr), 32'd0);
    check({tag, "_pt_addr"}, 32'(bus.pt_addr), 32'd0);
    check({tag, "_pt_din"}, bus.pt_din, 32'd0);
  endtask

  task automatic run(int L, int rst_at, int restart_at);
    int       lim;
    int       last;
    sym_exp_t se;
    bit_exp_t be;
    lim = (rst_at > 0) ? rst_at : 32'h4000_0000;
    model_run(L, lim);
    se.addr = 6'd0;
    se.cyc  = 1;
    exp_sym.push_back(se);
    for (int k = 0; k < L; k++) begin
      if (9 + 8 * k < lim) begin
        se.addr = 6'((k + 1) % 64);
        se.cyc  = 9 + 8 * k;
        exp_sym.push_back(se);
      end
    end
    if (rst_at == 0) exp_done.push_back(11 + 8 * L);

    @(negedge clk);
    check("busy_before_start", 32'(bus.busy), 32'd0);
    bus.codeblk_size_p7 = 6'(L);
    bus.start = 1'b1;
    start_cyc = cyc;
    be.val = 1'b1; be.cyc = 1; exp_busy.push_back(be);
    if (rst_at == 0) begin
      be.val = 1'b1; be.cyc = 11 + 8 * L; exp_busy.push_back(be);
      be.val = 1'b0; be.cyc = 12 + 8 * L; exp_busy.push_back(be);
    end

    last = 16 + 8 * L;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      if (c == 1) bus.codeblk_size_p7 = 6'd0;
      if (rst_at > 0 && c == rst_at - 1) begin
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_idle("in_reset");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        break;
      end
    end
    check("pt_queue_drained", exp_pt.size(), 32'd0);
    check("sym_queue_drained", exp_sym.size(), 32'd0);
    check("done_queue_drained", exp_done.size(), 32'd0);
    check("busy_queue_drained", exp_busy.size(), 32'd0);
    exp_pt.delete();
    exp_sym.delete();
    exp_done.delete();
    exp_busy.delete();
  endtask

  task automatic check_traceback();
    int          s;
    logic        d;
    logic [31:0] w;
    logic [28:0] dec;
    s   = 0;
    dec = '0;
    for (int k = 36; k >= 0; k--) begin
      w = cap[k * 8 + s / 32];
      d = w[s % 32];
      if (k < 29) dec[k] = 1'(s % 2);
      s = (d ? 128 : 0) + s / 2;
    end
    check("traceback_info_bits", 32'(dec), 32'(info_bits));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.codeblk_size_p7 = 6'd0;
    fill_sym(6'd0);
    for (int i = 0; i < 512; i++) cap[i] = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Strong all-zero codeword: state 0 survivor always comes from p0.
    fill_sym(6'd31);
    chk_bit0 = 1'b1;
    run(8, 0, 0);
    chk_bit0 = 1'b0;

    // All-zero soft input: every ACS is a tie.
    fill_sym(6'd0);
    chk_zero = 1'b1;
    run(36, 0, 0);
    chk_zero = 1'b0;

    // Clean encoded block, decoded back through a traceback.
    info_bits = 29'($urandom);
    encode(1'b0);
    run(36, 0, 0);
    check_traceback();

    // Same block with bounded noise.
    encode(1'b1);
    run(36, 0, 0);

    // Start pulse mid-run must be ignored.
    fill_sym(6'd31);
    run(8, 0, 20);

    // Reset mid-run, then a clean rerun of the first scenario.
    run(8, 40, 0);
    chk_bit0 = 1'b1;
    run(8, 0, 0);
    chk_bit0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
